// File: rtl/dclk_meter_pkg.sv
// Shared types and divider-ratio constants for the divided-clock meter.
package dclk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_e;

    // Divider ratio contract: select code -> period in clk_i cycles
    localparam int unsigned PERIOD_SEL0 = 2;
    localparam int unsigned PERIOD_SEL1 = 4;
    localparam int unsigned PERIOD_SEL2 = 8;
    localparam int unsigned PERIOD_SEL3 = 16;

    localparam logic [1:0] SEL_CODE0 = 2'd0;
    localparam logic [1:0] SEL_CODE1 = 2'd1;
    localparam logic [1:0] SEL_CODE2 = 2'd2;
    localparam logic [1:0] SEL_CODE3 = 2'd3;

    // Returns {legal, sel}; illegal periods decode to sel 0
    function automatic logic [2:0] decode_period(input logic [31:0] period);
        logic [2:0] res;
        res = 3'b000;
        case (period)
            PERIOD_SEL0: res = {1'b1, SEL_CODE0};
            PERIOD_SEL1: res = {1'b1, SEL_CODE1};
            PERIOD_SEL2: res = {1'b1, SEL_CODE2};
            PERIOD_SEL3: res = {1'b1, SEL_CODE3};
            default:     res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dclk_meter_sync_rise_det.sv
// Synchroniser chain for an asynchronous level, plus one delay flop to
// produce a single-cycle rising-edge strobe in the clk_i domain.
module sync_rise_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic async_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;

    // Shift the async level through the chain; s_q lags the last stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
            s_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            s_q    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~s_q;

endmodule

// File: rtl/dclk_meter.sv
// Measures period and high time of a divided clock in clk_i cycles and
// decodes the period back to the divider select code.
module dclk_meter
    import dclk_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             dclk_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic [1:0]       sel_o,
    output logic             sel_ok_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // cnt_q value at which the next increment would reach 2^CNT_W-2
    localparam logic [CNT_W-1:0] OVF_CNT = CNT_MAX - CNT_W'(2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [1:0]       sel_q, sel_d;
    logic             sel_ok_q, sel_ok_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             s;
    logic             rise;
    logic [CNT_W-1:0] period_next;
    logic [2:0]       dec;

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .async_i(dclk_i),
        .s_o    (s),
        .rise_o (rise)
    );

    assign period_next = cnt_q + CNT_W'(1);

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            sel_q    <= '0;
            sel_ok_q <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            sel_q    <= sel_d;
            sel_ok_q <= sel_ok_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state, counting and measurement capture; en_i low overrides all
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        sel_d    = sel_q;
        sel_ok_d = sel_ok_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        dec      = decode_period(32'(period_next));

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        hcnt_d  = CNT_W'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = period_next;
                        high_d   = hcnt_q;
                        sel_d    = dec[1:0];
                        sel_ok_d = dec[2];
                        valid_d  = 1'b1;
                        ovf_d    = 1'b0;
                        cnt_d    = '0;
                        hcnt_d   = CNT_W'(1);
                    end else if (cnt_q == OVF_CNT) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = period_next;
                        if (hcnt_q != CNT_MAX) begin
                            hcnt_d = hcnt_q + CNT_W'(s);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign period_o = period_q;
    assign high_o   = high_q;
    assign valid_o  = valid_q;
    assign sel_o    = sel_q;
    assign sel_ok_o = sel_ok_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_dclk_meter.sv
// Bench for dclk_meter: a 16-bit and a 4-bit instance share all inputs and
// are checked every cycle against an elapsed-time reference model.
module tb_dclk_meter;

    localparam int unsigned SYNC = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b0;
    logic dclk = 1'b0;

    logic [15:0] per_b, high_b;
    logic        val_b, ok_b, ovf_b;
    logic [1:0]  sel_b;
    logic [3:0]  per_s, high_s;
    logic        val_s, ok_s, ovf_s;
    logic [1:0]  sel_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dclk_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) u_big (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .dclk_i(dclk),
        .period_o(per_b), .high_o(high_b), .valid_o(val_b),
        .sel_o(sel_b), .sel_ok_o(ok_b), .ovf_o(ovf_b)
    );

    dclk_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) u_small (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .dclk_i(dclk),
        .period_o(per_s), .high_o(high_s), .valid_o(val_s),
        .sel_o(sel_s), .sel_ok_o(ok_s), .ovf_o(ovf_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0: 16-bit instance, index 1: 4-bit instance.
    int unsigned wid [2] = '{16, 4};
    int unsigned e_per [2], e_high [2], e_sel [2];
    bit          e_val [2], e_ok [2], e_ovf [2];
    bit          locked [2];   // a reference rise has been seen
    int unsigned elapsed [2];  // cycles since that rise (including it)
    int unsigned ones [2];     // cycles with s high since that rise
    bit          samples [$];  // dclk value sampled at each clk edge
    bit          en_prev;
    bit          m_s, m_sp, m_rise;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            samples = {};
            repeat (SYNC + 1) samples.push_back(1'b0);
            en_prev = 1'b0;
            for (int i = 0; i < 2; i++) begin
                e_per[i] = 0; e_high[i] = 0; e_sel[i] = 0;
                e_val[i] = 0; e_ok[i] = 0; e_ovf[i] = 0;
                locked[i] = 0; elapsed[i] = 0; ones[i] = 0;
            end
        end else begin
            // s in the ending cycle is dclk as sampled SYNC edges ago
            m_s    = samples[samples.size() - SYNC];
            m_sp   = samples[samples.size() - SYNC - 1];
            m_rise = m_s & ~m_sp;
            for (int i = 0; i < 2; i++) begin
                e_val[i] = 0;
                if (!en) begin
                    locked[i] = 0;
                end else if (!en_prev) begin
                    // first enabled cycle only leaves idle
                end else if (m_rise) begin
                    if (locked[i]) begin
                        e_per[i]  = elapsed[i];
                        e_high[i] = (ones[i] > (1 << wid[i]) - 1) ? (1 << wid[i]) - 1 : ones[i];
                        e_sel[i]  = 0;
                        e_ok[i]   = 0;
                        for (int k = 0; k < 4; k++)
                            if (elapsed[i] == (2 << k)) begin
                                e_sel[i] = k;
                                e_ok[i]  = 1;
                            end
                        e_val[i] = 1;
                        e_ovf[i] = 0;
                    end
                    locked[i]  = 1;
                    elapsed[i] = 1;
                    ones[i]    = 1;
                end else if (locked[i]) begin
                    if (elapsed[i] == (1 << wid[i]) - 2) begin
                        e_ovf[i]  = 1;
                        locked[i] = 0;
                    end else begin
                        elapsed[i]++;
                        ones[i] += m_s;
                    end
                end
            end
            en_prev = en;
            samples.push_back(dclk);
            if (samples.size() > 16) void'(samples.pop_front());
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("big.period", 32'(per_b), e_per[0]);
        chk("big.high",   32'(high_b), e_high[0]);
        chk("big.valid",  32'(val_b), 32'(e_val[0]));
        chk("big.sel",    32'(sel_b), e_sel[0]);
        chk("big.sel_ok", 32'(ok_b), 32'(e_ok[0]));
        chk("big.ovf",    32'(ovf_b), 32'(e_ovf[0]));
        chk("sm.period",  32'(per_s), e_per[1]);
        chk("sm.high",    32'(high_s), e_high[1]);
        chk("sm.valid",   32'(val_s), 32'(e_val[1]));
        chk("sm.sel",     32'(sel_s), e_sel[1]);
        chk("sm.sel_ok",  32'(ok_s), 32'(e_ok[1]));
        chk("sm.ovf",     32'(ovf_s), 32'(e_ovf[1]));
    end

    // ---------------- stimulus ----------------
    int unsigned ph;

    task automatic gen(input int unsigned p, input int unsigned h, input int unsigned n);
        ph = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dclk = (ph < h);
            ph = (ph + 1) % p;
        end
    endtask

    task automatic idle(input int unsigned n, input bit lvl);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dclk = lvl;
        end
    endtask

    task automatic set_en(input bit v);
        @(posedge clk);
        #1;
        en = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".period"}, 32'(per_b), 0);
        chk({tag, ".high"},   32'(high_b), 0);
        chk({tag, ".valid"},  32'(val_b), 0);
        chk({tag, ".sel"},    32'(sel_b), 0);
        chk({tag, ".sel_ok"}, 32'(ok_b), 0);
        chk({tag, ".ovf"},    32'(ovf_b), 0);
        chk({tag, ".sm_ovf"}, 32'(ovf_s), 0);
    endtask

    initial begin
        int unsigned p, h;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // sel=00 divider: period 2, high 1
        en = 1'b1;
        gen(2, 1, 40);
        chk("div2.period", 32'(per_b), 2);
        chk("div2.high",   32'(high_b), 1);
        chk("div2.sel",    32'(sel_b), 0);
        chk("div2.sel_ok", 32'(ok_b), 1);

        // sel=11 divider after re-enable: period 16, high 8
        set_en(1'b0);
        set_en(1'b1);
        gen(16, 8, 80);
        chk("div16.period", 32'(per_b), 16);
        chk("div16.high",   32'(high_b), 8);
        chk("div16.sel",    32'(sel_b), 3);
        chk("div16.sel_ok", 32'(ok_b), 1);

        // illegal ratio: period 6, high 2
        gen(6, 2, 40);
        chk("p6.period", 32'(per_b), 6);
        chk("p6.high",   32'(high_b), 2);
        chk("p6.sel",    32'(sel_b), 0);
        chk("p6.sel_ok", 32'(ok_b), 0);

        // dclk stuck low: the 4-bit instance saturates, the 16-bit one does not
        gen(4, 2, 8);
        idle(20, 1'b0);
        chk("stuck.sm_ovf",  32'(ovf_s), 1);
        chk("stuck.big_ovf", 32'(ovf_b), 0);
        gen(4, 2, 30);
        chk("resume.sm_ovf",    32'(ovf_s), 0);
        chk("resume.sm_period", 32'(per_s), 4);

        // enable gap mid-period
        gen(8, 4, 20);
        set_en(1'b0);
        gen(8, 4, 3);
        set_en(1'b1);
        gen(8, 4, 40);
        chk("engap.period", 32'(per_b), 8);

        // asynchronous reset in the middle of a measurement
        gen(4, 2, 13);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        gen(4, 2, 20);
        chk("postrst.period", 32'(per_b), 4);

        // randomized waveforms with occasional enable drops
        for (int seg = 0; seg < 40; seg++) begin
            p = $urandom_range(20, 2);
            h = $urandom_range(p - 1, 1);
            if ($urandom_range(7, 0) == 0) begin
                set_en(1'b0);
                idle($urandom_range(4, 1), dclk);
                set_en(1'b1);
            end
            if ($urandom_range(9, 0) == 0)
                idle($urandom_range(24, 10), $urandom_range(1, 0) == 1);
            gen(p, h, $urandom_range(80, 10));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
